// File: rtl/apb_requester.sv
// APB-style bus requester: one transfer at a time, host command/response
// ports, wait-state timeout so a silent slave cannot stall the host.
module apb_requester #(
  parameter int addrWidth     = 2,
  parameter int dataWidth     = 8,
  parameter int timeoutCycles = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [addrWidth-1:0] cmd_addr,
  input  logic [dataWidth-1:0] cmd_wdata,
  output logic                 rsp_valid,
  output logic [dataWidth-1:0] rsp_rdata,
  output logic                 rsp_err,
  output logic                 rsp_timeout,
  output logic                 sel,
  output logic                 enable,
  output logic                 write,
  output logic [addrWidth-1:0] addr,
  output logic [dataWidth-1:0] wdata,
  input  logic [dataWidth-1:0] rdata,
  input  logic                 ready,
  input  logic                 slverr
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_t;

  localparam bit       TimeoutOn = (timeoutCycles != 0);
  localparam logic [7:0] LastWait = 8'(timeoutCycles - 1);

  state_t     state;
  state_t     state_next;
  logic [7:0] wait_cnt;
  logic       timed_out;

  assign timed_out = TimeoutOn && (wait_cnt == LastWait);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:   if (cmd_valid) state_next = SETUP;
      SETUP:  state_next = ACCESS;
      ACCESS: if (ready || timed_out) state_next = RESP;
      RESP:   state_next = IDLE;
    endcase
  end

  // Handshake and bus strobes decode straight from the state register.
  assign cmd_ready = (state == IDLE);
  assign sel       = (state == SETUP) || (state == ACCESS);
  assign enable    = (state == ACCESS);
  assign rsp_valid = (state == RESP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write       <= 1'b0;
      addr        <= '0;
      wdata       <= '0;
      wait_cnt    <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            write <= cmd_write;
            addr  <= cmd_addr;
            wdata <= cmd_wdata;
          end
        end
        SETUP: wait_cnt <= '0;
        ACCESS: begin
          // A ready seen on the timeout edge still completes normally.
          if (ready) begin
            rsp_err     <= slverr;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= write ? '0 : rdata;
          end else if (timed_out) begin
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_rdata   <= '0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        RESP: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_requester.sv
// Scoreboard bench for apb_requester: directed and random transfers
// against a latency/response model, with a reactive slave.
module tb_apb_requester;
  localparam int AW = 2;
  localparam int DW = 8;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic          sel;
  logic          enable;
  logic          write;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          ready;
  logic          slverr;

  apb_requester #(
    .addrWidth(AW),
    .dataWidth(DW),
    .timeoutCycles(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .sel(sel),
    .enable(enable),
    .write(write),
    .addr(addr),
    .wdata(wdata),
    .rdata(rdata),
    .ready(ready),
    .slverr(slverr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    logic          to;
    int            lat;
    int            acc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(negedge clk) cyc <= cyc + 1;

  // Transfer currently on the bus, as seen by slave and monitor.
  int            cur_wait = 0;
  logic          cur_err = 1'b0;
  logic [DW-1:0] cur_rd = '0;
  logic          cur_write = 1'b0;
  logic [AW-1:0] cur_addr = '0;
  logic [DW-1:0] cur_wd = '0;

  logic [DW-1:0] hold_rd = '0;
  logic          hold_err = 1'b0;
  logic          hold_to = 1'b0;

  int prev_acc = 0;
  int prev_lat = 0;
  bit prev_hold = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  // Response and accept-to-response latency from the transfer rules.
  function automatic exp_t model(input bit wr, input int w, input bit er,
                                 input logic [DW-1:0] rd, input int acc);
    exp_t e;
    e.acc = acc;
    if (TO != 0 && w >= TO) begin
      e.rdata = '0;
      e.err   = 1'b1;
      e.to    = 1'b1;
      e.lat   = 2 + TO;
    end else begin
      e.rdata = wr ? '0 : rd;
      e.err   = er;
      e.to    = 1'b0;
      e.lat   = 3 + w;
    end
    return e;
  endfunction

  // Slave: raises ready after cur_wait ACCESS cycles, junk otherwise.
  initial begin
    int acnt;
    acnt   = 0;
    ready  = 1'b0;
    slverr = 1'b0;
    rdata  = '0;
    forever begin
      @(negedge clk);
      if (sel && enable) begin
        if (acnt == cur_wait) begin
          ready  = 1'b1;
          slverr = cur_err;
          rdata  = cur_rd;
        end else begin
          ready  = 1'b0;
          slverr = 1'($urandom);
          rdata  = 8'($urandom);
        end
        acnt++;
      end else begin
        ready  = 1'b0;
        acnt   = 0;
        slverr = 1'($urandom);
        rdata  = 8'($urandom);
      end
    end
  end

  // Monitor: bus rules every cycle, scoreboard pop on rsp_valid.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (enable && !sel) chk("enable_without_sel", 1, 0);
        if (sel && (cmd_ready || rsp_valid)) chk("sel_overlap", 1, 0);
        if (sel) begin
          chk("bus_addr", addr, cur_addr);
          chk("bus_write", write, cur_write);
          if (cur_write) chk("bus_wdata", wdata, cur_wd);
        end
        if (rsp_valid) begin
          if (sb.size() == 0) begin
            chk("unexpected_rsp", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_err", rsp_err, e.err);
            chk("rsp_timeout", rsp_timeout, e.to);
            chk("rsp_latency", cyc - e.acc, e.lat);
            hold_rd  = e.rdata;
            hold_err = e.err;
            hold_to  = e.to;
          end
        end else begin
          chk("hold_rdata", rsp_rdata, hold_rd);
          chk("hold_err", {rsp_err, rsp_timeout}, {hold_err, hold_to});
        end
      end
    end
  end

  // Call at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input bit wr, input logic [AW-1:0] ad,
                       input logic [DW-1:0] wd, input int w,
                       input bit er, input logic [DW-1:0] rd,
                       input bit hold);
    exp_t e;
    int   a;
    bit   got;
    a = 0;
    got = 1'b0;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = ad;
    cmd_wdata = wd;
    for (int i = 0; i < 64 && !got; i++) begin
      if (cmd_ready) begin
        a = cyc;
        got = 1'b1;
        @(posedge clk);
      end else begin
        @(negedge clk);
      end
    end
    if (!got) begin
      chk("accept_timeout", 0, 1);
      cmd_valid = 1'b0;
      return;
    end
    cur_write = wr;
    cur_addr  = ad;
    cur_wd    = wd;
    cur_wait  = w;
    cur_err   = er;
    cur_rd    = rd;
    e = model(wr, w, er, rd, a);
    sb.push_back(e);
    if (prev_hold) chk("b2b_gap", a - prev_acc, prev_lat + 1);
    prev_acc  = a;
    prev_lat  = e.lat;
    prev_hold = hold;
    @(negedge clk);
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_bus", {sel, enable, write, addr, wdata}, 0);
    chk("rst_rsp", {rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, 0);

    issue(1'b1, 2'd1, 8'h2A, 2, 1'b0, 8'h00, 1'b0);
    drain();
    issue(1'b0, 2'd2, 8'h00, 0, 1'b0, 8'h07, 1'b0);
    drain();
    repeat (3) @(negedge clk);
    issue(1'b1, 2'd2, 8'h99, 0, 1'b1, 8'h00, 1'b0);
    drain();
    issue(1'b0, 2'd3, 8'h00, 20, 1'b0, 8'hEE, 1'b0);
    drain();
    issue(1'b0, 2'd0, 8'h00, TO - 1, 1'b1, 8'h3C, 1'b0);
    drain();
    issue(1'b0, 2'd1, 8'h00, 0, 1'b0, 8'h11, 1'b1);
    issue(1'b0, 2'd2, 8'h00, 0, 1'b0, 8'h22, 1'b0);
    drain();

    for (int n = 0; n < 150; n++) begin
      bit hold;
      hold = 1'($urandom);
      issue(1'($urandom), 2'($urandom), 8'($urandom),
            int'($urandom_range(0, TO + 2)), 1'($urandom),
            8'($urandom), hold);
      if (!hold) repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    cmd_valid = 1'b0;
    drain();

    issue(1'b0, 2'd3, 8'h00, 1, 1'b0, 8'hA5, 1'b0);
    drain();
    issue(1'b0, 2'd1, 8'h00, 10, 1'b0, 8'h77, 1'b0);
    @(negedge clk);
    chk("pre_rst_enable", enable, 1);
    #2 reset = 1'b1;
    #1;
    chk("midrst_bus", {sel, enable}, 0);
    chk("midrst_rsp", {rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, 0);
    sb.delete();
    prev_hold = 1'b0;
    hold_rd   = '0;
    hold_err  = 1'b0;
    hold_to   = 1'b0;
    @(negedge clk);
    chk("inrst_rsp_valid", rsp_valid, 0);
    #3 reset = 1'b0;
    @(negedge clk);
    chk("post_rst_cmd_ready", cmd_ready, 1);
    issue(1'b0, 2'd2, 8'h00, 2, 1'b0, 8'h5C, 1'b0);
    drain();
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
